// File: rtl/rv32i_types.sv
// Shared RV32I decode types: opcodes, immediate formats, control word, decode stage register.
// Also holds the control ROM used by the decode stage.
package rv32i_types;

   localparam int unsigned RV_XLEN  = 32;
   localparam int unsigned RV_NREGS = 32;
   localparam int unsigned RV_RW    = $clog2(RV_NREGS);

   typedef enum logic [6:0] {
      OpLoad    = 7'b0000011,
      OpMiscMem = 7'b0001111,
      OpOpImm   = 7'b0010011,
      OpAuipc   = 7'b0010111,
      OpStore   = 7'b0100011,
      OpOp      = 7'b0110011,
      OpLui     = 7'b0110111,
      OpBranch  = 7'b1100011,
      OpJalr    = 7'b1100111,
      OpJal     = 7'b1101111,
      OpSystem  = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [2:0] {
      ImmNone = 3'd0,
      ImmI    = 3'd1,
      ImmS    = 3'd2,
      ImmB    = 3'd3,
      ImmU    = 3'd4,
      ImmJ    = 3'd5
   } rv32i_imm_fmt;

   typedef enum logic [3:0] {
      AluAdd   = 4'd0,
      AluSub   = 4'd1,
      AluSll   = 4'd2,
      AluSlt   = 4'd3,
      AluSltu  = 4'd4,
      AluXor   = 4'd5,
      AluSrl   = 4'd6,
      AluSra   = 4'd7,
      AluOr    = 4'd8,
      AluAnd   = 4'd9,
      AluPassB = 4'd10
   } rv32i_alu_op;

   typedef struct packed {
      rv32i_alu_op  alu_op;
      rv32i_imm_fmt imm_fmt;
      logic         alu_src_imm;
      logic         alu_src_pc;
      logic         reg_write;
      logic         mem_read;
      logic         mem_write;
      logic         branch;
      logic         jump;
      logic         illegal;
   } rv32i_control_word;

   typedef struct packed {
      logic [RV_XLEN-1:0] pc;
      logic [RV_XLEN-1:0] rs1_data;
      logic [RV_XLEN-1:0] rs2_data;
      logic [RV_XLEN-1:0] imm_i;
      logic [RV_XLEN-1:0] imm_s;
      logic [RV_XLEN-1:0] imm_b;
      logic [RV_XLEN-1:0] imm_u;
      logic [RV_XLEN-1:0] imm_j;
      logic [RV_RW-1:0]   rd;
      logic [RV_RW-1:0]   rs1;
      logic [RV_RW-1:0]   rs2;
      rv32i_control_word  ctrl;
   } stage_regs;

   // alt selects SUB/SRA; callers decide when funct7[5] is meaningful
   function automatic rv32i_alu_op alu_decode(input logic [2:0] funct3, input logic alt);
      case (funct3)
         3'b000:  return alt ? AluSub : AluAdd;
         3'b001:  return AluSll;
         3'b010:  return AluSlt;
         3'b011:  return AluSltu;
         3'b100:  return AluXor;
         3'b101:  return alt ? AluSra : AluSrl;
         3'b110:  return AluOr;
         default: return AluAnd;
      endcase
   endfunction

   function automatic rv32i_control_word control_rom(input logic [6:0] opcode,
                                                     input logic [2:0] funct3,
                                                     input logic       funct7_b5);
      rv32i_control_word c;
      c = '0;
      case (rv32i_opcode'(opcode))
         OpLui: begin
            c.imm_fmt     = ImmU;
            c.alu_op      = AluPassB;
            c.alu_src_imm = 1'b1;
            c.reg_write   = 1'b1;
         end
         OpAuipc: begin
            c.imm_fmt     = ImmU;
            c.alu_src_imm = 1'b1;
            c.alu_src_pc  = 1'b1;
            c.reg_write   = 1'b1;
         end
         OpJal: begin
            c.imm_fmt     = ImmJ;
            c.alu_src_imm = 1'b1;
            c.alu_src_pc  = 1'b1;
            c.reg_write   = 1'b1;
            c.jump        = 1'b1;
         end
         OpJalr: begin
            c.imm_fmt     = ImmI;
            c.alu_src_imm = 1'b1;
            c.reg_write   = 1'b1;
            c.jump        = 1'b1;
            c.illegal     = (funct3 != 3'b000);
         end
         OpBranch: begin
            c.imm_fmt = ImmB;
            c.alu_op  = AluSub;
            c.branch  = 1'b1;
            c.illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OpLoad: begin
            c.imm_fmt     = ImmI;
            c.alu_src_imm = 1'b1;
            c.reg_write   = 1'b1;
            c.mem_read    = 1'b1;
            c.illegal     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
         end
         OpStore: begin
            c.imm_fmt     = ImmS;
            c.alu_src_imm = 1'b1;
            c.mem_write   = 1'b1;
            c.illegal     = (funct3 > 3'b010);
         end
         OpOpImm: begin
            c.imm_fmt     = ImmI;
            c.alu_src_imm = 1'b1;
            c.reg_write   = 1'b1;
            c.alu_op      = alu_decode(funct3, (funct3 == 3'b101) && funct7_b5);
         end
         OpOp: begin
            c.reg_write = 1'b1;
            c.alu_op    = alu_decode(funct3, funct7_b5);
         end
         OpMiscMem, OpSystem: begin
            c.imm_fmt = ImmNone;
         end
         default: begin
            c.illegal = 1'b1;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/decode_hazard.sv
// Load-use hazard detection and fetch-side ready for the decode stage.
module decode_hazard
   import rv32i_types::*;
#(
   parameter int unsigned RW = RV_RW
) (
   input  logic          if_valid_i,
   input  logic [RW-1:0] rs1_i,
   input  logic [RW-1:0] rs2_i,
   input  logic          ex_load_i,
   input  logic [RW-1:0] ex_rd_i,
   input  logic          id_valid_i,
   input  logic          id_ready_i,
   output logic          hazard_o,
   output logic          if_ready_o
);

   always_comb begin
      hazard_o = if_valid_i && ex_load_i && (ex_rd_i != '0) &&
                 ((ex_rd_i == rs1_i) || (ex_rd_i == rs2_i));
      // flush deliberately does not gate ready; the squash happens in the stage register
      if_ready_o = !hazard_o && (!id_valid_i || id_ready_i);
   end

endmodule

// File: rtl/decode_pipe.sv
// RV32I decode stage: regfile read, immediate/control decode, one-deep stage register.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data into accepted operands.
module decode_pipe
   import rv32i_types::*;
#(
   parameter int unsigned XLEN  = RV_XLEN,
   parameter int unsigned NREGS = RV_NREGS,
   localparam int unsigned RW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [XLEN-1:0] if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output stage_regs       id_regs,
   input  logic            flush,
   input  logic            ex_load,
   input  logic [RW-1:0]   ex_rd,
   input  logic            wb_load,
   input  logic [RW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data
);

   logic [XLEN-1:0] rf_q [NREGS];
   logic            wb_we;
   logic [RW-1:0]   rs1_idx, rs2_idx, rd_idx;
   logic [XLEN-1:0] rs1_rd, rs2_rd, rs1_val, rs2_val;
   logic            hazard, accept;
   stage_regs       dec, stage_d, stage_q;
   logic            valid_d, valid_q;

   assign wb_we   = wb_load && (wb_rd != '0);
   assign rs1_idx = if_instr[15 +: RW];
   assign rs2_idx = if_instr[20 +: RW];
   assign rd_idx  = if_instr[7 +: RW];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_we) begin
         rf_q[wb_rd] <= wb_data;
      end
   end

   assign rs1_rd = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
   assign rs2_rd = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];

`ifdef DECODE_WB_BYPASS_EN
   assign rs1_val = (wb_we && (wb_rd == rs1_idx)) ? wb_data : rs1_rd;
   assign rs2_val = (wb_we && (wb_rd == rs2_idx)) ? wb_data : rs2_rd;
`else
   assign rs1_val = rs1_rd;
   assign rs2_val = rs2_rd;
`endif

   decode_hazard #(
      .RW(RW)
   ) u_hazard (
      .if_valid_i (if_valid),
      .rs1_i      (rs1_idx),
      .rs2_i      (rs2_idx),
      .ex_load_i  (ex_load),
      .ex_rd_i    (ex_rd),
      .id_valid_i (valid_q),
      .id_ready_i (id_ready),
      .hazard_o   (hazard),
      .if_ready_o (if_ready)
   );

   assign accept = if_valid && if_ready && !hazard;

   always_comb begin
      dec          = '0;
      dec.pc       = if_pc;
      dec.rs1_data = rs1_val;
      dec.rs2_data = rs2_val;
      dec.rd       = rd_idx;
      dec.rs1      = rs1_idx;
      dec.rs2      = rs2_idx;
      dec.imm_i    = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
      dec.imm_s    = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      dec.imm_b    = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                      if_instr[30:25], if_instr[11:8], 1'b0};
      dec.imm_u    = XLEN'($signed({if_instr[31:12], 12'b0}));
      dec.imm_j    = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                      if_instr[20], if_instr[30:21], 1'b0};
      dec.ctrl     = control_rom(if_instr[6:0], if_instr[14:12], if_instr[30]);
   end

   always_comb begin
      stage_d = stage_q;
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
         stage_d = dec;
      end else if (valid_q && !id_ready) begin
         // held operands must track a writeback that lands while execute is stalled
         if (wb_we && (wb_rd == stage_q.rs1)) stage_d.rs1_data = wb_data;
         if (wb_we && (wb_rd == stage_q.rs2)) stage_d.rs2_data = wb_data;
      end else begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         stage_q <= '0;
      end else begin
         valid_q <= valid_d;
         stage_q <= stage_d;
      end
   end

   assign id_valid = valid_q;
   assign id_regs  = stage_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed + randomized bench for decode_pipe against a transaction-level reference model.
module tb_decode_pipe;
   import rv32i_types::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_valid = 1'b0;
   logic        if_ready;
   logic [31:0] if_instr = '0;
   logic [31:0] if_pc = '0;
   logic        id_valid;
   logic        id_ready = 1'b1;
   stage_regs   id_regs;
   logic        flush = 1'b0;
   logic        ex_load = 1'b0;
   logic [4:0]  ex_rd = '0;
   logic        wb_load = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        valid;
      logic [31:0] pc, r1d, r2d, imm_i, imm_s, imm_b, imm_u, imm_j;
      logic [4:0]  rd, rs1, rs2;
   } exp_t;

   exp_t        exp_q;
   logic [31:0] rf [32];
   logic [6:0]  ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

   decode_pipe #(
      .XLEN(32),
      .NREGS(32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_valid (if_valid),
      .if_ready (if_ready),
      .if_instr (if_instr),
      .if_pc    (if_pc),
      .id_valid (id_valid),
      .id_ready (id_ready),
      .id_regs  (id_regs),
      .flush    (flush),
      .ex_load  (ex_load),
      .ex_rd    (ex_rd),
      .wb_load  (wb_load),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, want);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] rd_ref(input logic [4:0] r);
      return (r == 5'd0) ? 32'd0 : rf[r];
   endfunction

   // Immediates from their arithmetic definitions: signed top bits scaled plus placed fields
   function automatic exp_t tb_decode(input logic [31:0] in, input logic [31:0] pc);
      exp_t e;
      int   s, top7, sgn;
      s       = int'(in);
      top7    = s >>> 25;
      sgn     = s >>> 31;
      e.valid = 1'b1;
      e.pc    = pc;
      e.imm_i = s >>> 20;
      e.imm_s = top7 * 32 + in[11:7];
      e.imm_b = sgn * 4096 + in[7] * 2048 + in[30:25] * 32 + in[11:8] * 2;
      e.imm_u = (in >> 12) * 4096;
      e.imm_j = sgn * 1048576 + in[19:12] * 4096 + in[20] * 2048 + in[30:21] * 2;
      e.rd    = in[11:7];
      e.rs1   = in[19:15];
      e.rs2   = in[24:20];
      e.r1d   = '0;
      e.r2d   = '0;
      return e;
   endfunction

   task automatic model_reset();
      exp_q = '{default: 0};
      for (int i = 0; i < 32; i++) rf[i] = '0;
   endtask

   // Checks if_ready for the current inputs, then advances the model across one edge
   task automatic model_edge(input string tag);
      logic hz, rdy, acc, we;
      exp_t nxt;
      hz  = if_valid && ex_load && (ex_rd != 0) &&
            ((ex_rd == if_instr[19:15]) || (ex_rd == if_instr[24:20]));
      rdy = !hz && (!exp_q.valid || id_ready);
      chk({tag, ".if_ready"}, if_ready, rdy);
      acc = if_valid && rdy;
      we  = wb_load && (wb_rd != 0);
      nxt = exp_q;
      if (flush) begin
         nxt.valid = 1'b0;
      end else if (acc) begin
         nxt     = tb_decode(if_instr, if_pc);
         nxt.r1d = rd_ref(nxt.rs1);
         nxt.r2d = rd_ref(nxt.rs2);
`ifdef DECODE_WB_BYPASS_EN
         if (we && wb_rd == nxt.rs1) nxt.r1d = wb_data;
         if (we && wb_rd == nxt.rs2) nxt.r2d = wb_data;
`endif
      end else if (exp_q.valid && !id_ready) begin
         if (we && wb_rd == exp_q.rs1) nxt.r1d = wb_data;
         if (we && wb_rd == exp_q.rs2) nxt.r2d = wb_data;
      end else begin
         nxt.valid = 1'b0;
      end
      if (we) rf[wb_rd] = wb_data;
      exp_q = nxt;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".id_valid"}, id_valid, exp_q.valid);
      if (exp_q.valid) begin
         chk({tag, ".pc"}, id_regs.pc, exp_q.pc);
         chk({tag, ".rs1_data"}, id_regs.rs1_data, exp_q.r1d);
         chk({tag, ".rs2_data"}, id_regs.rs2_data, exp_q.r2d);
         chk({tag, ".imm_i"}, id_regs.imm_i, exp_q.imm_i);
         chk({tag, ".imm_s"}, id_regs.imm_s, exp_q.imm_s);
         chk({tag, ".imm_b"}, id_regs.imm_b, exp_q.imm_b);
         chk({tag, ".imm_u"}, id_regs.imm_u, exp_q.imm_u);
         chk({tag, ".imm_j"}, id_regs.imm_j, exp_q.imm_j);
         chk({tag, ".rd"}, id_regs.rd, exp_q.rd);
         chk({tag, ".rs1"}, id_regs.rs1, exp_q.rs1);
         chk({tag, ".rs2"}, id_regs.rs2, exp_q.rs2);
      end
   endtask

   task automatic cycle(input string tag);
      #1;
      model_edge(tag);
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      logic [31:0] ins;
      model_reset();

      // Reset state
      #2 rst = 1'b1;
      #1;
      chk("reset.id_valid", id_valid, 1'b0);
      chk("reset.pc", id_regs.pc, 32'd0);
      chk("reset.rs1_data", id_regs.rs1_data, 32'd0);
      chk("reset.ctrl", id_regs.ctrl, '0);
      chk("reset.if_ready", if_ready, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // ADDI x1,x0,5 at 0x100
      if_valid = 1'b1;
      if_instr = enc_i(5'd1, 5'd0, 12'd5);
      if_pc    = 32'h100;
      cycle("addi");
      chk("addi.id_valid", id_valid, 1'b1);
      chk("addi.imm_i", id_regs.imm_i, 32'd5);
      chk("addi.rd", id_regs.rd, 5'd1);
      chk("addi.pc", id_regs.pc, 32'h100);
      chk("addi.reg_write", id_regs.ctrl.reg_write, 1'b1);
      chk("addi.alu_src_imm", id_regs.ctrl.alu_src_imm, 1'b1);

      // Stall with execute not ready, then a writeback into the held rs1
      if_instr = enc_r(5'd5, 5'd1, 5'd2);
      if_pc    = 32'h104;
      cycle("hold.load");
      id_ready = 1'b0;
      if_instr = enc_i(5'd6, 5'd0, 12'd7);
      if_pc    = 32'h108;
      for (int i = 0; i < 3; i++) begin
         cycle("hold");
         chk("hold.if_ready", if_ready, 1'b0);
         chk("hold.rd", id_regs.rd, 5'd5);
         chk("hold.pc", id_regs.pc, 32'h104);
      end
      wb_load = 1'b1;
      wb_rd   = 5'd1;
      wb_data = 32'h55;
      cycle("hold.wb");
      wb_load = 1'b0;
      chk("hold.wb_rs1", id_regs.rs1_data, 32'h55);
      id_ready = 1'b1;
      cycle("hold.release");

      // Load-use hazard
      if_instr = enc_r(5'd4, 5'd3, 5'd2);
      if_pc    = 32'h10C;
      ex_load  = 1'b1;
      ex_rd    = 5'd3;
      #1 chk("hazard.if_ready", if_ready, 1'b0);
      cycle("hazard.stall");
      chk("hazard.bubble", id_valid, 1'b0);
      ex_load = 1'b0;
      #1 chk("hazard.clear", if_ready, 1'b1);
      cycle("hazard.go");
      chk("hazard.accepted", id_valid, 1'b1);
      chk("hazard.rd", id_regs.rd, 5'd4);

      // Flush squashes the beat offered in the same cycle
      flush    = 1'b1;
      if_instr = enc_i(5'd7, 5'd0, 12'd9);
      if_pc    = 32'h110;
      cycle("flush");
      chk("flush.id_valid", id_valid, 1'b0);
      flush    = 1'b0;
      if_valid = 1'b0;
      cycle("flush.after");
      chk("flush.after_valid", id_valid, 1'b0);

      // Writeback coinciding with accept
      if_valid = 1'b1;
      if_instr = enc_r(5'd8, 5'd1, 5'd2);
      if_pc    = 32'h114;
      wb_load  = 1'b1;
      wb_rd    = 5'd2;
      wb_data  = 32'hDEAD;
      cycle("wbacc");
`ifdef DECODE_WB_BYPASS_EN
      chk("wbacc.rs2_data", id_regs.rs2_data, 32'hDEAD);
`else
      chk("wbacc.rs2_data", id_regs.rs2_data, 32'h0);
`endif
      chk("wbacc.rs1_data", id_regs.rs1_data, 32'h55);
      wb_load  = 1'b0;
      if_instr = enc_r(5'd9, 5'd2, 5'd0);
      if_pc    = 32'h118;
      cycle("wbacc.after");
      chk("wbacc.after_rs1", id_regs.rs1_data, 32'hDEAD);

      // Writes to x0 are discarded
      if_valid = 1'b0;
      wb_load  = 1'b1;
      wb_rd    = 5'd0;
      wb_data  = 32'hFFFF;
      cycle("x0.write");
      wb_load  = 1'b0;
      if_valid = 1'b1;
      if_instr = enc_r(5'd10, 5'd0, 5'd0);
      if_pc    = 32'h11C;
      cycle("x0.read");
      chk("x0.rs1_data", id_regs.rs1_data, 32'h0);
      chk("x0.rs2_data", id_regs.rs2_data, 32'h0);

      // Asynchronous reset while holding, then accept on the first edge after release
      id_ready = 1'b0;
      if_instr = enc_r(5'd11, 5'd1, 5'd2);
      if_pc    = 32'h120;
      cycle("midrst.hold");
      #2 rst = 1'b1;
      #1;
      chk("midrst.id_valid", id_valid, 1'b0);
      chk("midrst.pc", id_regs.pc, 32'h0);
      chk("midrst.rs1_data", id_regs.rs1_data, 32'h0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      id_ready = 1'b1;
      if_instr = enc_r(5'd12, 5'd1, 5'd2);
      if_pc    = 32'h124;
      cycle("midrst.first");
      chk("midrst.first_valid", id_valid, 1'b1);
      chk("midrst.x1_cleared", id_regs.rs1_data, 32'h0);
      chk("midrst.x2_cleared", id_regs.rs2_data, 32'h0);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         ins        = $urandom;
         ins[6:0]   = ops[$urandom_range(0, 8)];
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         if_instr   = ins;
         if_pc      = $urandom & 32'hFFFF_FFFC;
         if_valid   = ($urandom_range(0, 3) != 0);
         id_ready   = ($urandom_range(0, 2) != 0);
         flush      = ($urandom_range(0, 15) == 0);
         ex_load    = ($urandom_range(0, 3) == 0);
         ex_rd      = 5'($urandom_range(0, 7));
         wb_load    = ($urandom_range(0, 1) == 0);
         wb_rd      = 5'($urandom_range(0, 7));
         wb_data    = $urandom;
         cycle("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
